// File: rtl/bwt_engine.sv
// bwt_engine: Burrows-Wheeler transform engine using prefix-doubling rank sort.
// Loads an N-symbol block, sorts suffixes (zero-padded) or cyclic rotations
// with an internal counting-rank sort, then streams the BWT column or the
// suffix array together with the primary index.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cfg_cyclic, cfg_out_sa  mode select, latched on first accepted input beat
//   in_valid/in_ready/in_data          symbol input stream
//   out_valid/out_ready/out_data/out_last  result stream (N words)
//   primary_idx             position p where sa[p]==0
//   busy                    high whenever not idle
module bwt_engine #(
    parameter int N      = 32,
    parameter int CHAR_W = 8,
    localparam int IDX_W  = $clog2(N),
    localparam int OUT_W  = (CHAR_W > IDX_W) ? CHAR_W : IDX_W,
    localparam int RANK_W = OUT_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cyclic,
    input  logic              cfg_out_sa,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  primary_idx,
    output logic              busy
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KEYS, S_SORT, S_RERANK, S_CHECK, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W:0]     k_q, k_d;
    logic [RANK_W-1:0]  maxrank_q, maxrank_d;
    logic [IDX_W-1:0]   pidx_q, pidx_d;
    logic               cyc_q, cyc_d, osa_q, osa_d;
    logic               rdy_en_q;
    logic [CHAR_W-1:0]  txt_q [N], txt_d [N];
    logic [RANK_W-1:0]  rank_q [N], rank_d [N];
    logic [RANK_W-1:0]  key1_q [N], key1_d [N];
    logic [RANK_W-1:0]  key2_q [N], key2_d [N];
    logic [IDX_W-1:0]   sa_q [N], sa_d [N];

    logic               last_cnt;
    logic [2*RANK_W-1:0] key_cur;
    logic [IDX_W-1:0]   sort_pos;
    logic [IDX_W-1:0]   rr_cur, rr_prv;
    logic               rr_diff;
    logic [RANK_W-1:0]  rr_rank;
    logic               len_done;
    logic [IDX_W-1:0]   bwt_src;

    // Reduce an (i+k) sum, at most 2N-2, back into 0..N-1.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] s);
        if (s >= (IDX_W+1)'(N)) return IDX_W'(s - (IDX_W+1)'(N));
        return IDX_W'(s);
    endfunction

    assign last_cnt = (cnt_q == IDX_W'(N-1));

    // Rank-sort position of element cnt_q: entries with smaller key, or equal
    // key and lower index, go before it. The result always fits in IDX_W bits.
    always_comb begin
        key_cur  = {key1_q[cnt_q], key2_q[cnt_q]};
        sort_pos = '0;
        for (int j = 0; j < N; j++) begin
            if (({key1_q[j], key2_q[j]} < key_cur) ||
                (({key1_q[j], key2_q[j]} == key_cur) && (IDX_W'(j) < cnt_q)))
                sort_pos = sort_pos + IDX_W'(1);
        end
    end

    // Dense re-ranking: maxrank_q doubles as the previous position's rank.
    always_comb begin
        rr_cur  = sa_q[cnt_q];
        rr_prv  = sa_q[(cnt_q == '0) ? cnt_q : cnt_q - IDX_W'(1)];
        rr_diff = ({key1_q[rr_cur], key2_q[rr_cur]} != {key1_q[rr_prv], key2_q[rr_prv]});
        rr_rank = (cnt_q == '0) ? RANK_W'(1) : maxrank_q + RANK_W'(rr_diff);
    end

    // Prefix length sorted after this pass is 1 for k==0, else 2k.
    assign len_done = (k_q != '0) && ({k_q, 1'b0} >= (IDX_W+2)'(N));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        maxrank_d = maxrank_q;
        pidx_d    = pidx_q;
        cyc_d     = cyc_q;
        osa_d     = osa_q;
        txt_d     = txt_q;
        rank_d    = rank_q;
        key1_d    = key1_q;
        key2_d    = key2_q;
        sa_d      = sa_q;
        case (state_q)
            S_IDLE: if (in_valid && in_ready) begin
                txt_d[0]  = in_data;
                rank_d[0] = RANK_W'(in_data) + RANK_W'(1);
                cyc_d     = cfg_cyclic;
                osa_d     = cfg_out_sa;
                cnt_d     = IDX_W'(1);
                state_d   = S_LOAD;
            end
            S_LOAD: if (in_valid && in_ready) begin
                txt_d[cnt_q]  = in_data;
                rank_d[cnt_q] = RANK_W'(in_data) + RANK_W'(1);
                if (last_cnt) begin
                    cnt_d   = '0;
                    k_d     = '0;
                    state_d = S_KEYS;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_KEYS: begin
                for (int i = 0; i < N; i++) begin
                    key1_d[i] = rank_q[i];
                    if (k_q == '0)
                        key2_d[i] = '0;
                    else if ((((IDX_W+1)'(i) + k_q) < (IDX_W+1)'(N)) || cyc_q)
                        key2_d[i] = rank_q[wrap_idx((IDX_W+1)'(i) + k_q)];
                    else
                        key2_d[i] = '0;
                end
                cnt_d   = '0;
                state_d = S_SORT;
            end
            S_SORT: begin
                sa_d[sort_pos] = cnt_q;
                cnt_d   = last_cnt ? '0 : cnt_q + IDX_W'(1);
                if (last_cnt) state_d = S_RERANK;
            end
            S_RERANK: begin
                rank_d[rr_cur] = rr_rank;
                maxrank_d      = rr_rank;
                if (rr_cur == '0) pidx_d = cnt_q;
                cnt_d   = last_cnt ? '0 : cnt_q + IDX_W'(1);
                if (last_cnt) state_d = S_CHECK;
            end
            S_CHECK: begin
                cnt_d = '0;
                if ((maxrank_q == RANK_W'(N)) || len_done) begin
                    state_d = S_OUT;
                end else begin
                    k_d     = (k_q == '0) ? (IDX_W+1)'(1) : {k_q[IDX_W-1:0], 1'b0};
                    state_d = S_KEYS;
                end
            end
            S_OUT: if (out_ready) begin
                cnt_d = last_cnt ? '0 : cnt_q + IDX_W'(1);
                if (last_cnt) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            maxrank_q <= '0;
            pidx_q    <= '0;
            cyc_q     <= 1'b0;
            osa_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                txt_q[i]  <= '0;
                rank_q[i] <= '0;
                key1_q[i] <= '0;
                key2_q[i] <= '0;
                sa_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            maxrank_q <= maxrank_d;
            pidx_q    <= pidx_d;
            cyc_q     <= cyc_d;
            osa_q     <= osa_d;
            rdy_en_q  <= 1'b1;   // keeps in_ready low for the first cycle out of reset
            txt_q     <= txt_d;
            rank_q    <= rank_d;
            key1_q    <= key1_d;
            key2_q    <= key2_d;
            sa_q      <= sa_d;
        end
    end

    // BWT symbol is the one preceding the suffix start, wrapping at 0.
    assign bwt_src     = (sa_q[cnt_q] == '0) ? IDX_W'(N-1) : sa_q[cnt_q] - IDX_W'(1);
    assign in_ready    = rdy_en_q && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign out_valid   = (state_q == S_OUT);
    assign out_data    = !out_valid ? '0 : (osa_q ? OUT_W'(sa_q[cnt_q]) : OUT_W'(txt_q[bwt_src]));
    assign out_last    = out_valid && last_cnt;
    assign primary_idx = pidx_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bwt_engine.sv
// Bench for bwt_engine: three instances (N=6, 4, 32) share clock and reset.
// Expected words are queued before each block is driven and popped as the
// DUT hands them over.
module tb_bwt_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cfg_cyclic, cfg_out_sa, in_valid, in_ready;
    logic [2:0] out_valid, out_ready, out_last, busy;
    logic [7:0] in_data [3];
    logic [7:0] out_data [3];
    logic [2:0] pidx0;
    logic [1:0] pidx1;
    logic [4:0] pidx2;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp_pidx;
    int txt_m[32];
    int sa_m[32];
    int n_m;

    always #5 clk = ~clk;

    bwt_engine #(.N(6), .CHAR_W(8)) u_n6 (
        .clk(clk), .rst_n(rst_n), .cfg_cyclic(cfg_cyclic[0]), .cfg_out_sa(cfg_out_sa[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .primary_idx(pidx0), .busy(busy[0]));

    bwt_engine #(.N(4), .CHAR_W(8)) u_n4 (
        .clk(clk), .rst_n(rst_n), .cfg_cyclic(cfg_cyclic[1]), .cfg_out_sa(cfg_out_sa[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .primary_idx(pidx1), .busy(busy[1]));

    bwt_engine #(.N(32), .CHAR_W(8)) u_n32 (
        .clk(clk), .rst_n(rst_n), .cfg_cyclic(cfg_cyclic[2]), .cfg_out_sa(cfg_out_sa[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .primary_idx(pidx2), .busy(busy[2]));

    function automatic int get_pidx(input int s);
        case (s)
            0:       return int'(pidx0);
            1:       return int'(pidx1);
            default: return int'(pidx2);
        endcase
    endfunction

    task automatic set_txt(input string str);
        n_m = str.len();
        for (int i = 0; i < n_m; i++) txt_m[i] = int'(str[i]);
    endtask

    task automatic push_str(input string str);
        for (int i = 0; i < str.len(); i++) exp_q.push_back(int'(str[i]));
    endtask

    // Reference: direct lexicographic comparison of whole suffixes/rotations.
    function automatic int sym(input int p, input bit cyc);
        if (cyc) return txt_m[p % n_m] + 1;
        return (p < n_m) ? txt_m[p] + 1 : 0;
    endfunction

    function automatic bit ref_less(input int a, input int b, input bit cyc);
        for (int m = 0; m < n_m; m++) begin
            if (sym(a + m, cyc) != sym(b + m, cyc)) return sym(a + m, cyc) < sym(b + m, cyc);
        end
        return a < b;
    endfunction

    task automatic model_push(input bit cyc, input bit osa);
        int t;
        for (int i = 0; i < n_m; i++) sa_m[i] = i;
        for (int i = 1; i < n_m; i++) begin
            for (int j = i; j > 0; j--) begin
                if (ref_less(sa_m[j], sa_m[j-1], cyc)) begin
                    t = sa_m[j]; sa_m[j] = sa_m[j-1]; sa_m[j-1] = t;
                end
            end
        end
        for (int p = 0; p < n_m; p++) begin
            exp_q.push_back(osa ? sa_m[p] : txt_m[(sa_m[p] + n_m - 1) % n_m]);
            if (sa_m[p] == 0) exp_pidx = p;
        end
    endtask

    task automatic load_block(input int s, input bit cyc, input bit osa, input bit rnd, input string nm);
        int  i = 0;
        int  cyc_cnt = 0;
        bit  acc;
        @(negedge clk);
        cfg_cyclic[s] = cyc;
        cfg_out_sa[s] = osa;
        while (i < n_m && cyc_cnt < 2000) begin
            in_valid[s] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data[s]  = 8'(txt_m[i]);
            acc = in_valid[s] && in_ready[s];
            @(posedge clk);
            if (acc) i++;
            @(negedge clk);
            cyc_cnt++;
        end
        in_valid[s] = 1'b0;
        total++;
        if (i != n_m) begin
            bad++;
            $display("FAIL %s_load: accepted %0d beats, want %0d", nm, i, n_m);
        end
    endtask

    task automatic drain_block(input int s, input bit rnd, input string nm, output int lat);
        int   nexp = exp_q.size();
        int   got = 0;
        int   cyc_cnt = 0;
        int   w;
        bit   stalled = 0;
        logic [7:0] hold_d;
        logic hold_l;
        int   hold_p;
        out_ready[s] = 1'b0;
        lat = 0;
        while (!out_valid[s] && lat < 5000) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        while (got < nexp && cyc_cnt < 5000) begin
            if (stalled) begin
                total++;
                if (!out_valid[s] || out_data[s] !== hold_d || out_last[s] !== hold_l || get_pidx(s) != hold_p) begin
                    bad++;
                    $display("FAIL %s_stall: v=%0b d=%0d l=%0b p=%0d, want v=1 d=%0d l=%0b p=%0d",
                             nm, out_valid[s], out_data[s], out_last[s], get_pidx(s), hold_d, hold_l, hold_p);
                end
            end
            out_ready[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
            if (out_valid[s]) begin
                if (out_ready[s]) begin
                    w = exp_q.pop_front();
                    total += 3;
                    if (int'(out_data[s]) != w) begin
                        bad++;
                        $display("FAIL %s_word%0d: got %0d want %0d", nm, got, out_data[s], w);
                    end
                    if (out_last[s] !== (got == nexp - 1)) begin
                        bad++;
                        $display("FAIL %s_last%0d: got %0b want %0b", nm, got, out_last[s], got == nexp - 1);
                    end
                    if (get_pidx(s) != exp_pidx) begin
                        bad++;
                        $display("FAIL %s_pidx: got %0d want %0d", nm, get_pidx(s), exp_pidx);
                    end
                    got++;
                end else begin
                    stalled = 1;
                    hold_d = out_data[s];
                    hold_l = out_last[s];
                    hold_p = get_pidx(s);
                end
            end else if (got > 0) begin
                total++; bad++;
                $display("FAIL %s_gap: out_valid dropped after %0d words", nm, got);
            end
            @(posedge clk); @(negedge clk);
            cyc_cnt++;
        end
        out_ready[s] = 1'b0;
        total++;
        if (got != nexp) begin
            bad++;
            $display("FAIL %s_count: got %0d words want %0d", nm, got, nexp);
        end
        total++;
        if (in_ready[s] !== 1'b1 || busy[s] !== 1'b0 || out_valid[s] !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: rdy=%0b busy=%0b v=%0b want 1 0 0", nm, in_ready[s], busy[s], out_valid[s]);
        end
        exp_q.delete();
    endtask

    task automatic check_lat(input string nm, input int lat, input int want);
        total++;
        if (lat != want) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", nm, lat, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if ({in_ready[s], out_valid[s], out_last[s], busy[s]} !== 4'b0 ||
                out_data[s] !== 8'd0 || get_pidx(s) != 0) begin
                bad++;
                $display("FAIL reset_outputs%0d: rdy=%0b v=%0b l=%0b busy=%0b d=%0d p=%0d want all 0",
                         s, in_ready[s], out_valid[s], out_last[s], busy[s], out_data[s], get_pidx(s));
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 3'b000) begin
            bad++;
            $display("FAIL reset_ready_early: got %b want 000", in_ready);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 3'b111) begin
            bad++;
            $display("FAIL reset_ready_rise: got %b want 111", in_ready);
        end
    endtask

    task automatic test_banana();
        int lat;
        set_txt("banana"); push_str("nnbaaa"); exp_pidx = 3;
        load_block(0, 1'b0, 1'b0, 1'b0, "banana_sfx_bwt");
        drain_block(0, 1'b0, "banana_sfx_bwt", lat);
        check_lat("banana_sfx_bwt", lat, 42);
        exp_q = '{5, 3, 1, 0, 4, 2}; exp_pidx = 3;
        load_block(0, 1'b1, 1'b1, 1'b0, "banana_cyc_sa");
        drain_block(0, 1'b0, "banana_cyc_sa", lat);
    endtask

    task automatic test_periodic();
        int lat;
        set_txt("abab");
        push_str("bbaa"); exp_pidx = 0;
        load_block(1, 1'b1, 1'b0, 1'b0, "abab_cyc_bwt");
        drain_block(1, 1'b0, "abab_cyc_bwt", lat);
        check_lat("abab_cyc_bwt", lat, 30);
        exp_q = '{0, 2, 1, 3}; exp_pidx = 0;
        load_block(1, 1'b1, 1'b1, 1'b0, "abab_cyc_sa");
        drain_block(1, 1'b0, "abab_cyc_sa", lat);
        exp_q = '{2, 0, 3, 1}; exp_pidx = 1;
        load_block(1, 1'b0, 1'b1, 1'b0, "abab_sfx_sa");
        drain_block(1, 1'b0, "abab_sfx_sa", lat);
        push_str("bbaa"); exp_pidx = 1;
        load_block(1, 1'b0, 1'b0, 1'b0, "abab_sfx_bwt");
        drain_block(1, 1'b0, "abab_sfx_bwt", lat);
    endtask

    task automatic test_uniform();
        int lat;
        set_txt("aaaa");
        exp_q = '{3, 2, 1, 0}; exp_pidx = 3;
        load_block(1, 1'b0, 1'b1, 1'b0, "aaaa_sfx_sa");
        drain_block(1, 1'b0, "aaaa_sfx_sa", lat);
        push_str("aaaa"); exp_pidx = 3;
        load_block(1, 1'b0, 1'b0, 1'b0, "aaaa_sfx_bwt");
        drain_block(1, 1'b0, "aaaa_sfx_bwt", lat);
    endtask

    task automatic test_backpressure();
        int lat;
        n_m = 32;
        for (int i = 0; i < 32; i++) txt_m[i] = 97 + int'($urandom_range(0, 3));
        model_push(1'b0, 1'b0);
        load_block(2, 1'b0, 1'b0, 1'b1, "rand_sfx_bwt");
        drain_block(2, 1'b1, "rand_sfx_bwt", lat);
        for (int i = 0; i < 32; i++) txt_m[i] = 97 + int'($urandom_range(0, 2));
        model_push(1'b1, 1'b1);
        load_block(2, 1'b1, 1'b1, 1'b1, "rand_cyc_sa");
        drain_block(2, 1'b1, "rand_cyc_sa", lat);
    endtask

    task automatic test_reset_mid_sort();
        int lat;
        set_txt("banana");
        load_block(0, 1'b0, 1'b0, 1'b0, "abort");
        repeat (4) @(negedge clk);
        total++;
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before: got %0b want 1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs: busy=%0b v=%0b rdy=%0b want 0 0 0", busy[0], out_valid[0], in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_str("nnbaaa"); exp_pidx = 3;
        load_block(0, 1'b0, 1'b0, 1'b0, "after_abort");
        drain_block(0, 1'b0, "after_abort", lat);
    endtask

    initial begin
        cfg_cyclic = '0; cfg_out_sa = '0; in_valid = '0; out_ready = '0;
        for (int s = 0; s < 3; s++) in_data[s] = 8'd0;
        test_reset();
        test_banana();
        test_periodic();
        test_uniform();
        test_backpressure();
        test_reset_mid_sort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bwt_engine.md
# bwt_engine

Parametrised Burrows–Wheeler transform engine: next generation of the prefix-doubling suffix sorter. It accepts an N-symbol block as a valid/ready stream and sorts suffixes (or cyclic rotations) with an internal rank sort, so no external merge-sort instance is needed. It then streams out either the BWT last column or the suffix array, plus the primary index. It sits between the block buffer and the entropy-coder front end.

## Interface
- N, 32: block length in symbols, ≥2.
- CHAR_W, 8: symbol width.
- IDX_W (localparam): $clog2(N); index width.
- RANK_W (localparam): max(CHAR_W, IDX_W)+1; rank width, rank 0 reserved for "past end".
- OUT_W (localparam): max(CHAR_W, IDX_W).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_cyclic  in  1  1 = sort cyclic rotations; 0 = sort suffixes, zero-padded past end. Sampled on first accepted input beat.
- cfg_out_sa  in  1  1 = output suffix array; 0 = output BWT column. Sampled with cfg_cyclic.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  high in IDLE and LOAD.
- in_data  in  CHAR_W  input symbol; beat i is txt[i].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  BWT symbol or SA entry, zero-extended.
- out_last  out  1  high with word N-1.
- primary_idx  out  IDX_W  position p where sa[p]==0; valid from first out_valid until next load begins.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, KEYS, SORT, RERANK, CHECK, OUT.
- IDLE: the first in_valid&in_ready beat stores txt[0], rank[0]=in_data+1, latches cfg, and enters LOAD.
- LOAD: stores txt[i], rank[i]=in_data+1. The beat with i==N-1 goes to KEYS with k=0.
- KEYS (1 cycle): latch key1[i]=rank[i] for all i. key2[i] is set as follows:
  - k==0: 0.
  - i+k<N: rank[i+k].
  - Otherwise: cyclic → rank[i+k-N]; suffix → 0.
- SORT (N cycles, element i on cycle i): pos = count of j with (key1,key2)[j] < (key1,key2)[i] lexicographically, or equal with j<i. Write sa[pos]=i. The sort is stable and ties break by index.
- RERANK (N cycles, position p on cycle p):
  - p==0: rank[sa[0]]=1.
  - Otherwise rank[sa[p]] = prev+1 if keys of sa[p] and sa[p-1] differ, else prev.
  - Track maxrank.
- CHECK (1 cycle): go to OUT if maxrank==N or 2k≥N (k==0 counts as sorted prefix length 1). Otherwise set k = (k==0 ? 1 : 2k) and return to KEYS. In cyclic mode, periodic inputs terminate by length and equal rotations remain in index order.
- OUT: word p is either sa[p] (cfg_out_sa=1) or txt[(sa[p]+N-1) mod N] (cfg_out_sa=0).
  - Advance p on out_valid&out_ready.
  - The word-(N-1) handshake returns to IDLE.
- primary_idx is captured during RERANK as the p where sa[p]==0.
- Inputs presented outside IDLE/LOAD are ignored, because in_ready=0.

## Timing
- Reset (async assert, sync-safe deassert) drives state IDLE and clears all counters. Output values during reset: in_ready=0, out_valid=0, out_data=0, out_last=0, primary_idx=0, busy=0. in_ready rises one clk after deassertion.
- Reset asserted mid-LOAD, mid-sort or mid-OUT aborts immediately and discards the partial block. The next block starts clean.
- Load takes N accepted beats. Each pass takes 2N+2 cycles. Passes ≤ 1+ceil(log2 N).
- First out_valid occurs the cycle after the final CHECK. With out_ready held high, words stream one per cycle.
- out_data, out_last and primary_idx hold stable while out_valid&!out_ready.
- in_ready is 0 from the cycle after the last load beat until the cycle after the last output handshake. A new block may begin loading on that cycle.
- All index arithmetic wraps modulo N. i+k is computed at IDX_W+1 bits, so it does not overflow.

## Test plan
- N=6, suffix mode, BWT output, "banana" → out "nnbaaa", primary_idx=3, out_last on word 5.
- N=6, cyclic mode, SA output, "banana" → out 5,3,1,0,4,2, primary_idx=3.
- N=4, cyclic mode, BWT output, "abab" (periodic) → out "bbaa", sa=0,2,1,3, primary_idx=0. Also terminates after the pass reaching length 4. The same input in suffix mode → SA 2,0,3,1, BWT "bbaa", primary_idx=1.
- N=4, suffix mode, "aaaa" → SA 3,2,1,0. BWT "aaaa", primary_idx=3.
- Backpressure: N=32 random block with in_valid and out_ready toggled pseudo-randomly → output matches the software BWT model. Data stays stable during stalls, and exactly N output handshakes occur.
- Reset: assert rst_n low mid-SORT → busy=0 and out_valid=0 immediately. A following "banana" block in suffix mode then yields "nnbaaa" correctly.
